// File: rtl/maze_pkg.sv
// Shared maze constants: default dimensions, wall-vector widths, move directions and player FSM states.
package maze_pkg;

   localparam int unsigned COLS     = 16;
   localparam int unsigned ROWS     = 11;
   localparam int unsigned H_WALL_W = COLS * (ROWS - 1);
   localparam int unsigned V_WALL_W = (COLS - 1) * ROWS;

   localparam int unsigned POS_W    = 4;
   localparam int unsigned STEP_W   = 16;
   localparam int unsigned DIR_W    = 2;

   localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
   localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
   localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [1:0] {
      WAIT_MAZE = 2'd0,
      IDLE      = 2'd1,
      CHECK     = 2'd2,
      DONE      = 2'd3
   } state_t;

endpackage

// File: rtl/maze_wall_lookup.sv
// Combinational wall/border check for one move from cell (x,y) in direction dir.
module maze_wall_lookup #(
   parameter int unsigned COLS = maze_pkg::COLS,
   parameter int unsigned ROWS = maze_pkg::ROWS
) (
   input  logic [maze_pkg::POS_W-1:0]  i_x,
   input  logic [maze_pkg::POS_W-1:0]  i_y,
   input  logic [maze_pkg::DIR_W-1:0]  i_dir,
   input  logic [COLS*(ROWS-1)-1:0]    i_h_walls,
   input  logic [(COLS-1)*ROWS-1:0]    i_v_walls,
   output logic                        o_blocked_c
);
   import maze_pkg::*;

   localparam int unsigned H_W  = COLS * (ROWS - 1);
   localparam int unsigned V_W  = (COLS - 1) * ROWS;
   localparam int unsigned HI_W = $clog2(H_W);
   localparam int unsigned VI_W = $clog2(V_W);

   localparam logic [POS_W-1:0] X_MAX = POS_W'(COLS - 1);
   localparam logic [POS_W-1:0] Y_MAX = POS_W'(ROWS - 1);

   logic [HI_W-1:0] w_h_idx;
   logic [VI_W-1:0] w_v_idx;

   // Border moves are refused outright; otherwise exactly one wall bit decides.
   always_comb begin
      w_h_idx     = '0;
      w_v_idx     = '0;
      o_blocked_c = 1'b0;
      case (i_dir)
         DIR_UP: begin
            if (i_y == '0) begin
               o_blocked_c = 1'b1;
            end else begin
               w_h_idx     = HI_W'((32'(i_y) - 32'd1) * COLS + 32'(i_x));
               o_blocked_c = i_h_walls[w_h_idx];
            end
         end
         DIR_DOWN: begin
            if (i_y == Y_MAX) begin
               o_blocked_c = 1'b1;
            end else begin
               w_h_idx     = HI_W'(32'(i_y) * COLS + 32'(i_x));
               o_blocked_c = i_h_walls[w_h_idx];
            end
         end
         DIR_LEFT: begin
            if (i_x == '0) begin
               o_blocked_c = 1'b1;
            end else begin
               w_v_idx     = VI_W'(32'(i_y) * (COLS - 1) + 32'(i_x) - 32'd1);
               o_blocked_c = i_v_walls[w_v_idx];
            end
         end
         default: begin
            if (i_x == X_MAX) begin
               o_blocked_c = 1'b1;
            end else begin
               w_v_idx     = VI_W'(32'(i_y) * (COLS - 1) + 32'(i_x));
               o_blocked_c = i_v_walls[w_v_idx];
            end
         end
      endcase
   end

endmodule

// File: rtl/maze_player.sv
// Player controller: accepts one move at a time, checks it against the maze walls,
// tracks position and step count, and flags reaching the exit cell.
module maze_player #(
   parameter int unsigned COLS = maze_pkg::COLS,
   parameter int unsigned ROWS = maze_pkg::ROWS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         maze_busy,
   input  logic [COLS*(ROWS-1)-1:0]     h_walls,
   input  logic [(COLS-1)*ROWS-1:0]     v_walls,
   input  logic                         move_valid,
   input  logic [maze_pkg::DIR_W-1:0]   move_dir,
   output logic                         move_ready,
   output logic                         move_ack,
   output logic                         move_blocked,
   output logic [maze_pkg::POS_W-1:0]   player_x,
   output logic [maze_pkg::POS_W-1:0]   player_y,
   output logic [maze_pkg::STEP_W-1:0]  step_count,
   output logic                         win
);
   import maze_pkg::*;

   localparam logic [POS_W-1:0]  X_EXIT   = POS_W'(COLS - 1);
   localparam logic [POS_W-1:0]  Y_EXIT   = POS_W'(ROWS - 1);
   localparam logic [STEP_W-1:0] STEP_MAX = '1;

   state_t             r_state, w_state_nxt;
   logic               r_phase, w_phase_nxt;
   logic [DIR_W-1:0]   r_dir,   w_dir_nxt;
   logic               r_blk,   w_blk_nxt;
   logic [POS_W-1:0]   r_x,     w_x_nxt;
   logic [POS_W-1:0]   r_y,     w_y_nxt;
   logic [STEP_W-1:0]  r_steps, w_steps_nxt;
   logic               r_win,   w_win_nxt;
   logic               r_ack,   w_ack_nxt;
   logic               r_blocked, w_blocked_nxt;
   logic               r_ready, w_ready_nxt;
   logic               w_blocked_c;

   maze_wall_lookup #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_lookup (
      .i_x         (r_x),
      .i_y         (r_y),
      .i_dir       (r_dir),
      .i_h_walls   (h_walls),
      .i_v_walls   (v_walls),
      .o_blocked_c (w_blocked_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= WAIT_MAZE;
         r_phase   <= 1'b0;
         r_dir     <= DIR_UP;
         r_blk     <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_steps   <= '0;
         r_win     <= 1'b0;
         r_ack     <= 1'b0;
         r_blocked <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_dir     <= w_dir_nxt;
         r_blk     <= w_blk_nxt;
         r_x       <= w_x_nxt;
         r_y       <= w_y_nxt;
         r_steps   <= w_steps_nxt;
         r_win     <= w_win_nxt;
         r_ack     <= w_ack_nxt;
         r_blocked <= w_blocked_nxt;
         r_ready   <= w_ready_nxt;
      end
   end

   // CHECK spans two cycles: phase 0 samples the wall lookup, phase 1 commits the move.
   always_comb begin
      w_state_nxt   = r_state;
      w_phase_nxt   = 1'b0;
      w_dir_nxt     = r_dir;
      w_blk_nxt     = r_blk;
      w_x_nxt       = r_x;
      w_y_nxt       = r_y;
      w_steps_nxt   = r_steps;
      w_win_nxt     = r_win;
      w_ack_nxt     = 1'b0;
      w_blocked_nxt = r_blocked;

      case (r_state)
         WAIT_MAZE: begin
            w_state_nxt = IDLE;
         end
         IDLE: begin
            if (move_valid && r_ready) begin
               w_dir_nxt   = move_dir;
               w_state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (!r_phase) begin
               w_blk_nxt   = w_blocked_c;
               w_phase_nxt = 1'b1;
            end else begin
               w_ack_nxt     = 1'b1;
               w_blocked_nxt = r_blk;
               if (!r_blk) begin
                  case (r_dir)
                     DIR_UP:    w_y_nxt = r_y - POS_W'(1);
                     DIR_DOWN:  w_y_nxt = r_y + POS_W'(1);
                     DIR_LEFT:  w_x_nxt = r_x - POS_W'(1);
                     default:   w_x_nxt = r_x + POS_W'(1);
                  endcase
                  if (r_steps != STEP_MAX) begin
                     w_steps_nxt = r_steps + STEP_W'(1);
                  end
               end
               if (w_x_nxt == X_EXIT && w_y_nxt == Y_EXIT) begin
                  w_state_nxt = DONE;
                  w_win_nxt   = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         DONE: begin
            w_state_nxt = DONE;
         end
         default: begin
            w_state_nxt = WAIT_MAZE;
         end
      endcase

      // A maze rebuild discards any move in flight and restarts the player.
      if (maze_busy) begin
         w_state_nxt = WAIT_MAZE;
         w_phase_nxt = 1'b0;
         w_x_nxt     = '0;
         w_y_nxt     = '0;
         w_steps_nxt = '0;
         w_win_nxt   = 1'b0;
         w_ack_nxt   = 1'b0;
      end

      w_ready_nxt = (w_state_nxt == IDLE);
   end

   assign move_ready   = r_ready;
   assign move_ack     = r_ack;
   assign move_blocked = r_blocked;
   assign player_x     = r_x;
   assign player_y     = r_y;
   assign step_count   = r_steps;
   assign win          = r_win;

endmodule
